// File: rtl/reservation_station.sv
// Purpose: ALU reservation station; buffers dispatched ops, snoops the CDB for operand tags, and issues one ready entry per cycle.
// Latency: an operand-ready dispatch at edge N issues at edge N+1. A CDB wakeup issues one edge after the broadcast (same edge with RS_WAKEUP_ISSUE_EN).
// Backpressure: full_out refuses dispatch, alu_idle_in low holds issue, and rdy_in low freezes all state. The optional macro is RS_WAKEUP_ISSUE_EN.
module reservation_station #(
   parameter int RS_SIZE    = 8,
   parameter int OP_WIDTH   = 6,
   parameter int DATA_WIDTH = 32,
   parameter int ROB_WIDTH  = 4
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  rdy_in,
   input  logic                  flush_in,
   input  logic                  disp_valid_in,
   input  logic [OP_WIDTH-1:0]   disp_op_in,
   input  logic                  disp_qj_pend_in,
   input  logic [ROB_WIDTH-1:0]  disp_qj_in,
   input  logic [DATA_WIDTH-1:0] disp_vj_in,
   input  logic                  disp_qk_pend_in,
   input  logic [ROB_WIDTH-1:0]  disp_qk_in,
   input  logic [DATA_WIDTH-1:0] disp_vk_in,
   input  logic [DATA_WIDTH-1:0] disp_imm_in,
   input  logic [ROB_WIDTH-1:0]  disp_rob_id_in,
   output logic                  full_out,
   input  logic                  cdb_valid_in,
   input  logic [ROB_WIDTH-1:0]  cdb_rob_id_in,
   input  logic [DATA_WIDTH-1:0] cdb_result_in,
   input  logic                  alu_idle_in,
   output logic                  alu_rdy_out,
   output logic [OP_WIDTH-1:0]   alu_op_out,
   output logic [DATA_WIDTH-1:0] alu_vj_out,
   output logic [DATA_WIDTH-1:0] alu_vk_out,
   output logic [DATA_WIDTH-1:0] alu_imm_out,
   output logic [ROB_WIDTH-1:0]  alu_rob_id_out
);
   localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

   typedef struct packed {
      logic                  busy;
      logic [OP_WIDTH-1:0]   op;
      logic                  qj_pend;
      logic [ROB_WIDTH-1:0]  qj;
      logic [DATA_WIDTH-1:0] vj;
      logic                  qk_pend;
      logic [ROB_WIDTH-1:0]  qk;
      logic [DATA_WIDTH-1:0] vk;
      logic [DATA_WIDTH-1:0] imm;
      logic [ROB_WIDTH-1:0]  rob_id;
   } entry_t;

   entry_t                rs_q [RS_SIZE];
   logic [RS_SIZE-1:0]    busy_vec;
   logic [RS_SIZE-1:0]    hit_j;
   logic [RS_SIZE-1:0]    hit_k;
   logic [RS_SIZE-1:0]    cand;
   logic                  iss_found;
   logic [IDX_W-1:0]      iss_idx;
   logic                  free_found;
   logic [IDX_W-1:0]      free_idx;
   logic                  disp_ok;
   logic                  issue_ok;
   logic [DATA_WIDTH-1:0] iss_vj;
   logic [DATA_WIDTH-1:0] iss_vk;
   entry_t                new_entry;

   // Per-entry CDB tag match and issue candidacy from registered state
   always_comb begin
      busy_vec = '0;
      hit_j    = '0;
      hit_k    = '0;
      cand     = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         busy_vec[i] = rs_q[i].busy;
         hit_j[i] = rs_q[i].busy & rs_q[i].qj_pend & cdb_valid_in & (rs_q[i].qj == cdb_rob_id_in);
         hit_k[i] = rs_q[i].busy & rs_q[i].qk_pend & cdb_valid_in & (rs_q[i].qk == cdb_rob_id_in);
`ifdef RS_WAKEUP_ISSUE_EN
         cand[i] = rs_q[i].busy & (~rs_q[i].qj_pend | hit_j[i]) & (~rs_q[i].qk_pend | hit_k[i]);
`else
         cand[i] = rs_q[i].busy & ~rs_q[i].qj_pend & ~rs_q[i].qk_pend;
`endif
      end
   end

   assign full_out = &busy_vec;

   // Priority pick: lowest-index issue candidate and lowest-index free slot
   always_comb begin
      iss_found  = 1'b0;
      iss_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (!iss_found && cand[i]) begin
            iss_found = 1'b1;
            iss_idx   = IDX_W'(i);
         end
         if (!free_found && !busy_vec[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   assign issue_ok = alu_idle_in & iss_found;
   assign disp_ok  = disp_valid_in & ~full_out;

   // Issued operands, forwarding the live broadcast when the wakeup path is enabled
   always_comb begin
      iss_vj = rs_q[iss_idx].vj;
      iss_vk = rs_q[iss_idx].vk;
`ifdef RS_WAKEUP_ISSUE_EN
      if (hit_j[iss_idx]) iss_vj = cdb_result_in;
      if (hit_k[iss_idx]) iss_vk = cdb_result_in;
`endif
   end

   // New entry, capturing an operand produced by the same-cycle broadcast
   always_comb begin
      new_entry         = '0;
      new_entry.busy    = 1'b1;
      new_entry.op      = disp_op_in;
      new_entry.qj      = disp_qj_in;
      new_entry.qk      = disp_qk_in;
      new_entry.imm     = disp_imm_in;
      new_entry.rob_id  = disp_rob_id_in;
      new_entry.qj_pend = disp_qj_pend_in;
      new_entry.vj      = disp_vj_in;
      new_entry.qk_pend = disp_qk_pend_in;
      new_entry.vk      = disp_vk_in;
      if (disp_qj_pend_in && cdb_valid_in && disp_qj_in == cdb_rob_id_in) begin
         new_entry.qj_pend = 1'b0;
         new_entry.vj      = cdb_result_in;
      end
      if (disp_qk_pend_in && cdb_valid_in && disp_qk_in == cdb_rob_id_in) begin
         new_entry.qk_pend = 1'b0;
         new_entry.vk      = cdb_result_in;
      end
   end

   // Entry state and issue register: flush beats snoop/issue/dispatch, rdy_in low freezes
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < RS_SIZE; i++) rs_q[i] <= '0;
         alu_rdy_out    <= 1'b0;
         alu_op_out     <= '0;
         alu_vj_out     <= '0;
         alu_vk_out     <= '0;
         alu_imm_out    <= '0;
         alu_rob_id_out <= '0;
      end else if (!rdy_in) begin
         alu_rdy_out <= 1'b0;
      end else if (flush_in) begin
         for (int i = 0; i < RS_SIZE; i++) rs_q[i].busy <= 1'b0;
         alu_rdy_out <= 1'b0;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (hit_j[i]) begin
               rs_q[i].qj_pend <= 1'b0;
               rs_q[i].vj      <= cdb_result_in;
            end
            if (hit_k[i]) begin
               rs_q[i].qk_pend <= 1'b0;
               rs_q[i].vk      <= cdb_result_in;
            end
         end
         alu_rdy_out <= issue_ok;
         if (issue_ok) begin
            rs_q[iss_idx].busy <= 1'b0;
            alu_op_out         <= rs_q[iss_idx].op;
            alu_vj_out         <= iss_vj;
            alu_vk_out         <= iss_vk;
            alu_imm_out        <= rs_q[iss_idx].imm;
            alu_rob_id_out     <= rs_q[iss_idx].rob_id;
         end
         if (disp_ok) rs_q[free_idx] <= new_entry;
      end
   end
endmodule

// File: tb/tb_reservation_station.sv
// Purpose: directed check of reservation_station dispatch, CDB wakeup, issue order, flush and reset.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: exercises full_out refusal, alu_idle_in hold and rdy_in freeze.
module tb_reservation_station;
   localparam logic [5:0] ADD = 6'h01;
   localparam logic [5:0] SUB = 6'h02;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rdy, flush, dv, qjp, qkp, cv, idle;
   logic [5:0]  op;
   logic [3:0]  qj, qk, rob, ct;
   logic [31:0] vj, vk, imm, cr;
   logic        full, a_rdy;
   logic [5:0]  a_op;
   logic [31:0] a_vj, a_vk, a_imm;
   logic [3:0]  a_rob;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reservation_station dut (
      .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .flush_in(flush),
      .disp_valid_in(dv), .disp_op_in(op),
      .disp_qj_pend_in(qjp), .disp_qj_in(qj), .disp_vj_in(vj),
      .disp_qk_pend_in(qkp), .disp_qk_in(qk), .disp_vk_in(vk),
      .disp_imm_in(imm), .disp_rob_id_in(rob), .full_out(full),
      .cdb_valid_in(cv), .cdb_rob_id_in(ct), .cdb_result_in(cr),
      .alu_idle_in(idle), .alu_rdy_out(a_rdy), .alu_op_out(a_op),
      .alu_vj_out(a_vj), .alu_vk_out(a_vk), .alu_imm_out(a_imm),
      .alu_rob_id_out(a_rob)
   );

   typedef struct {
      logic dv; logic [5:0] op;
      logic qjp; logic [3:0] qj; logic [31:0] vj;
      logic qkp; logic [3:0] qk; logic [31:0] vk;
      logic [31:0] imm; logic [3:0] rob;
      logic cv; logic [3:0] ct; logic [31:0] cr;
      logic idle; logic fl; logic rdy;
      logic e_full; logic e_rdy; logic [5:0] e_op;
      logic [31:0] e_vj; logic [31:0] e_vk; logic [31:0] e_imm; logic [3:0] e_rob;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(
      input logic d, input logic [5:0] o,
      input logic jp, input logic [3:0] j, input logic [31:0] jv,
      input logic kp, input logic [3:0] k, input logic [31:0] kv,
      input logic [31:0] im, input logic [3:0] rb,
      input logic c, input logic [3:0] t, input logic [31:0] r,
      input logic id, input logic f, input logic rd,
      input logic ef, input logic er, input logic [5:0] eo,
      input logic [31:0] ej, input logic [31:0] ek, input logic [31:0] ei, input logic [3:0] eb);
      vec_t x;
      x.dv = d; x.op = o; x.qjp = jp; x.qj = j; x.vj = jv;
      x.qkp = kp; x.qk = k; x.vk = kv; x.imm = im; x.rob = rb;
      x.cv = c; x.ct = t; x.cr = r; x.idle = id; x.fl = f; x.rdy = rd;
      x.e_full = ef; x.e_rdy = er; x.e_op = eo;
      x.e_vj = ej; x.e_vk = ek; x.e_imm = ei; x.e_rob = eb;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic quiet();
      dv = 0; op = '0; qjp = 0; qj = '0; vj = '0; qkp = 0; qk = '0; vk = '0;
      imm = '0; rob = '0; cv = 0; ct = '0; cr = '0; idle = 1; flush = 0; rdy = 1;
   endtask

   task automatic disp(input logic [5:0] o, input logic jp, input logic [3:0] j, input logic [31:0] jv,
                       input logic kp, input logic [3:0] k, input logic [31:0] kv,
                       input logic [31:0] im, input logic [3:0] rb);
      dv = 1; op = o; qjp = jp; qj = j; vj = jv; qkp = kp; qk = k; vk = kv; imm = im; rob = rb;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      @(negedge clk);
      quiet();
   endtask

   task automatic chk_issue(input string name, input logic [5:0] eo, input logic [31:0] ej,
                            input logic [31:0] ek, input logic [3:0] eb);
      chk({name, "_rdy"}, 32'(a_rdy), 32'd1);
      chk({name, "_op"},  32'(a_op),  32'(eo));
      chk({name, "_vj"},  a_vj, ej);
      chk({name, "_vk"},  a_vk, ek);
      chk({name, "_rob"}, 32'(a_rob), 32'(eb));
   endtask

   initial begin
      quiet();
      rst_n = 0;
      #12;
      chk("reset_rdy", 32'(a_rdy), 32'd0);
      chk("reset_full", 32'(full), 32'd0);
      chk("reset_op", 32'(a_op), 32'd0);
      chk("reset_rob", 32'(a_rob), 32'd0);
      @(negedge clk);
      rst_n = 1;

      // cycle table: d op jp j vj kp k vk imm rob | cv ct cr | idle fl rdy | exp full rdy op vj vk imm rob
      tbl.push_back(mk(0,0,  0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,1, 0,0,0,0,0,0,0));
      // single ready ADD issues one edge after dispatch, strobe lasts one cycle
      tbl.push_back(mk(1,ADD,0,0,5, 0,0,7, 32'h11,3, 0,0,0, 1,0,1, 0,0,0,0,0,0,0));
      tbl.push_back(mk(0,0,  0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,1, 0,1,ADD,5,7,32'h11,3));
      tbl.push_back(mk(0,0,  0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,1, 0,0,0,0,0,0,0));
      // SUB waiting on tag 2, broadcast two cycles later
      tbl.push_back(mk(1,SUB,1,2,0, 0,0,1, 32'h20,4, 0,0,0, 1,0,1, 0,0,0,0,0,0,0));
      tbl.push_back(mk(0,0,  0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,1, 0,0,0,0,0,0,0));
`ifdef RS_WAKEUP_ISSUE_EN
      tbl.push_back(mk(0,0,  0,0,0, 0,0,0, 0,0, 1,2,32'h10, 1,0,1, 0,1,SUB,32'h10,1,32'h20,4));
      tbl.push_back(mk(0,0,  0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,1, 0,0,0,0,0,0,0));
`else
      tbl.push_back(mk(0,0,  0,0,0, 0,0,0, 0,0, 1,2,32'h10, 1,0,1, 0,0,0,0,0,0,0));
      tbl.push_back(mk(0,0,  0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,1, 0,1,SUB,32'h10,1,32'h20,4));
`endif
      tbl.push_back(mk(0,0,  0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,1, 0,0,0,0,0,0,0));
      // two ready entries held while the ALU is busy, then drained in index order
      tbl.push_back(mk(1,ADD,0,0,1, 0,0,2, 0,5, 0,0,0, 0,0,1, 0,0,0,0,0,0,0));
      tbl.push_back(mk(1,SUB,0,0,3, 0,0,4, 0,6, 0,0,0, 0,0,1, 0,0,0,0,0,0,0));
      tbl.push_back(mk(0,0,  0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,1, 0,0,0,0,0,0,0));
      tbl.push_back(mk(0,0,  0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,1, 0,0,0,0,0,0,0));
      tbl.push_back(mk(0,0,  0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,1, 0,1,ADD,1,2,0,5));
      tbl.push_back(mk(0,0,  0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,1, 0,1,SUB,3,4,0,6));
      tbl.push_back(mk(0,0,  0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,1, 0,0,0,0,0,0,0));
      // both operands produced by the broadcast in the dispatch cycle
      tbl.push_back(mk(1,ADD,1,7,0, 1,7,0, 32'h33,8, 1,7,32'h55, 1,0,1, 0,0,0,0,0,0,0));
      tbl.push_back(mk(0,0,  0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,1, 0,1,ADD,32'h55,32'h55,32'h33,8));
      tbl.push_back(mk(0,0,  0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,1, 0,0,0,0,0,0,0));
      // dispatch while rdy_in low is frozen out entirely
      tbl.push_back(mk(1,ADD,0,0,9, 0,0,9, 0,9, 0,0,0, 1,0,0, 0,0,0,0,0,0,0));
      tbl.push_back(mk(0,0,  0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,1, 0,0,0,0,0,0,0));

      foreach (tbl[n]) begin
         dv = tbl[n].dv; op = tbl[n].op; qjp = tbl[n].qjp; qj = tbl[n].qj; vj = tbl[n].vj;
         qkp = tbl[n].qkp; qk = tbl[n].qk; vk = tbl[n].vk; imm = tbl[n].imm; rob = tbl[n].rob;
         cv = tbl[n].cv; ct = tbl[n].ct; cr = tbl[n].cr; idle = tbl[n].idle;
         flush = tbl[n].fl; rdy = tbl[n].rdy;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_full", n), 32'(full), 32'(tbl[n].e_full));
         chk($sformatf("v%0d_rdy", n), 32'(a_rdy), 32'(tbl[n].e_rdy));
         if (tbl[n].e_rdy) begin
            chk($sformatf("v%0d_op", n), 32'(a_op), 32'(tbl[n].e_op));
            chk($sformatf("v%0d_vj", n), a_vj, tbl[n].e_vj);
            chk($sformatf("v%0d_vk", n), a_vk, tbl[n].e_vk);
            chk($sformatf("v%0d_imm", n), a_imm, tbl[n].e_imm);
            chk($sformatf("v%0d_rob", n), 32'(a_rob), 32'(tbl[n].e_rob));
         end
         @(negedge clk);
         quiet();
      end

      // fill all eight entries waiting on tag 9, then a ninth dispatch is refused
      for (int i = 0; i < 8; i++) begin
         disp(ADD, 1, 9, 0, 1, 9, 0, 0, 4'(i));
         step();
      end
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_no_issue", 32'(a_rdy), 32'd0);
      disp(SUB, 0, 0, 1, 0, 0, 1, 0, 4'd15);
      step();
      chk("ninth_full", 32'(full), 32'd1);
      cv = 1; ct = 4'd9; cr = 32'h99;
      @(posedge clk);
      #1;
`ifdef RS_WAKEUP_ISSUE_EN
      chk_issue("drain0", ADD, 32'h99, 32'h99, 4'd0);
      chk("drain0_full", 32'(full), 32'd0);
      @(negedge clk);
      quiet();
      for (int i = 1; i < 8; i++) begin
         step();
         chk_issue($sformatf("drain%0d", i), ADD, 32'h99, 32'h99, 4'(i));
      end
`else
      chk("wake_no_issue", 32'(a_rdy), 32'd0);
      @(negedge clk);
      quiet();
      for (int i = 0; i < 8; i++) begin
         step();
         chk_issue($sformatf("drain%0d", i), ADD, 32'h99, 32'h99, 4'(i));
         if (i == 0) chk("drain0_full", 32'(full), 32'd0);
      end
`endif
      step();
      chk("ninth_dropped", 32'(a_rdy), 32'd0);

      // flush wipes four waiting entries; later wakeup finds nothing to issue
      for (int i = 0; i < 4; i++) begin
         disp(SUB, 1, 10, 0, 0, 0, 2, 0, 4'(i + 1));
         step();
      end
      flush = 1;
      disp(ADD, 0, 0, 1, 0, 0, 1, 0, 4'd12);
      cv = 1; ct = 4'd10; cr = 32'hAA;
      step();
      chk("flush_full", 32'(full), 32'd0);
      chk("flush_rdy", 32'(a_rdy), 32'd0);
      cv = 1; ct = 4'd10; cr = 32'hAA;
      step();
      chk("flush_wake_rdy", 32'(a_rdy), 32'd0);
      step();
      chk("flush_wake_rdy2", 32'(a_rdy), 32'd0);
      disp(ADD, 0, 0, 32'h21, 0, 0, 32'h22, 0, 4'd2);
      step();
      step();
      chk_issue("post_flush", ADD, 32'h21, 32'h22, 4'd2);

      // asynchronous reset mid-cycle while the strobe is high
      disp(SUB, 0, 0, 32'h31, 0, 0, 32'h32, 0, 4'd7);
      step();
      @(posedge clk);
      #1;
      chk_issue("pre_reset", SUB, 32'h31, 32'h32, 4'd7);
      #2;
      rst_n = 0;
      #1;
      chk("async_rst_rdy", 32'(a_rdy), 32'd0);
      chk("async_rst_op", 32'(a_op), 32'd0);
      chk("async_rst_full", 32'(full), 32'd0);
      @(negedge clk);
      rst_n = 1;
      quiet();
      step();
      chk("after_rst_rdy", 32'(a_rdy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
